// File: rtl/riscv_pkg.sv
// Shared constants for the multicycle RISC-V controller: state encoding,
// opcodes, ALU operation codes, immediate formats and the ImmSrc mapping.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU-operation class plus the funct fields to an ALUControl code.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic       aluop_valid,
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // funct3 = 000 subtracts only for R-type (op5 set) so addi never subtracts
  always_comb begin
    alu_control = ALU_ADD;
    if (aluop_valid) begin
      case (aluop)
        ALUOP_ADD: alu_control = ALU_ADD;
        ALUOP_SUB: alu_control = ALU_SUB;
        ALUOP_FUNCT: begin
          case (funct3)
            3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
          endcase
        end
        default: alu_control = ALU_ADD;
      endcase
    end else begin
      alu_control = ALU_ADD;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM controller for a multicycle RISC-V datapath (lw, sw, R/I-type ALU, beq, jal).
module multicycle_control
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite
);

  state_t     state_q;
  state_t     state_d;
  aluop_t     aluop_s;
  logic       pc_write_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic [2:0] alu_control_s;

  alu_decoder u_alu_decoder (
    .aluop_valid (1'b1),
    .aluop       (aluop_s),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d     = S_FETCH;
    pc_write_s  = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    aluop_s     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        state_d    = S_DECODE;
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        AdrSrc  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_EXECUTER: begin
        state_d = S_ALUWB;
        ALUSrcA = 2'b10;
        aluop_s = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        state_d = S_ALUWB;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop_s = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        aluop_s    = ALUOP_SUB;
        pc_write_s = zero;
      end
      S_JAL: begin
        state_d    = S_ALUWB;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_s = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // The state register already reads FETCH during reset; only the enables need masking
  assign PCWrite    = pc_write_s  & ~reset;
  assign IRWrite    = ir_write_s  & ~reset;
  assign MemWrite   = mem_write_s & ~reset;
  assign RegWrite   = reg_write_s & ~reset;
  assign ALUControl = alu_control_s;
  assign ImmSrc     = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, corner-case
// sequences and randomized instructions against a per-instruction timeline model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [15:0] act_s;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  assign act_s = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, RegWrite};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111;

  function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
      input logic irw, input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
      input logic [2:0] alu, input logic [1:0] imm, input logic rw);
    return {pcw, adr, mw, irw, res, sa, sb, alu, imm, rw};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic int model_lat(input logic [6:0] o);
    if (o == LW) return 5;
    if (o == SW || o == RT || o == IT || o == JAL) return 4;
    if (o == BEQ) return 3;
    return 2;
  endfunction

  // Expected outputs in cycle k (1 = fetch) of an instruction with opcode o
  function automatic logic [15:0] model_out(input logic [6:0] o, input logic [2:0] f3,
      input logic f7, input logic z, input int k);
    logic [1:0] im;
    im = imm_of(o);
    if (k == 1) return mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, im, 1'b0);
    if (k == 2) return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, im, 1'b0);
    if ((o == LW || o == SW) && k == 3)
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, im, 1'b0);
    if ((o == LW || o == SW) && k == 4)
      return mk(1'b0, 1'b1, (o == SW), 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1'b0);
    if (o == LW && k == 5)
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, im, 1'b1);
    if (o == RT && k == 3)
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, funct_alu(o, f3, f7), im, 1'b0);
    if (o == IT && k == 3)
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, funct_alu(o, f3, f7), im, 1'b0);
    if (o == JAL && k == 3)
      return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, im, 1'b0);
    if ((o == RT || o == IT || o == JAL) && k == 4)
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1'b1);
    if (o == BEQ && k == 3)
      return mk(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, im, 1'b0);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1'b0);
  endfunction

  function automatic logic [15:0] reset_out(input logic [6:0] o);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm_of(o), 1'b0);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Runs one instruction from its FETCH cycle; called at posedge+1, returns at posedge+1
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input string tag);
    int lat;
    lat = model_lat(o);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int k = 1; k <= lat; k++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      #1;
      check($sformatf("%s cyc%0d", tag, k), act_s, model_out(o, f3, f7, zero, k));
      @(posedge clk); #1;
    end
    check($sformatf("%s back_to_fetch", tag), act_s, model_out(o, f3, f7, zero, 1));
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         lat;
    logic [2:0] alu3;
    logic [1:0] imm;
    logic       pcw3;
  } vec_t;

  vec_t tbl[13];

  task automatic run_vec(input vec_t v, input int idx);
    int   seen;
    logic [2:0] alu_c;
    logic [1:0] imm_c;
    logic pcw_c;
    seen = -1; alu_c = 3'b000; imm_c = 2'b00; pcw_c = 1'b0;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
    for (int k = 1; k <= v.lat; k++) begin
      #1;
      if (k == 2) imm_c = ImmSrc;
      if (k == 3) begin alu_c = ALUControl; pcw_c = PCWrite; end
      if (k > 1 && IRWrite && seen < 0) seen = k - 1;
      @(posedge clk); #1;
    end
    if (IRWrite && seen < 0) seen = v.lat;
    check($sformatf("vec%0d latency", idx), 16'(seen), 16'(v.lat));
    check($sformatf("vec%0d immsrc", idx), 16'(imm_c), 16'(v.imm));
    if (v.lat >= 3) begin
      check($sformatf("vec%0d alucontrol", idx), 16'(alu_c), 16'(v.alu3));
      check($sformatf("vec%0d pcwrite3", idx), 16'(pcw_c), 16'(v.pcw3));
    end
  endtask

  initial begin
    logic [6:0] legal [6];
    logic [6:0] ro;
    legal[0] = LW; legal[1] = SW; legal[2] = RT; legal[3] = IT; legal[4] = BEQ; legal[5] = JAL;

    tbl[0]  = '{LW,  3'b010, 1'b0, 1'b0, 5, 3'b000, 2'b00, 1'b0};
    tbl[1]  = '{SW,  3'b010, 1'b0, 1'b0, 4, 3'b000, 2'b01, 1'b0};
    tbl[2]  = '{RT,  3'b000, 1'b1, 1'b0, 4, 3'b001, 2'b00, 1'b0};
    tbl[3]  = '{IT,  3'b000, 1'b1, 1'b0, 4, 3'b000, 2'b00, 1'b0};
    tbl[4]  = '{RT,  3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b00, 1'b0};
    tbl[5]  = '{RT,  3'b010, 1'b0, 1'b0, 4, 3'b101, 2'b00, 1'b0};
    tbl[6]  = '{IT,  3'b110, 1'b0, 1'b0, 4, 3'b011, 2'b00, 1'b0};
    tbl[7]  = '{RT,  3'b111, 1'b1, 1'b0, 4, 3'b010, 2'b00, 1'b0};
    tbl[8]  = '{RT,  3'b001, 1'b0, 1'b0, 4, 3'b000, 2'b00, 1'b0};
    tbl[9]  = '{BEQ, 3'b000, 1'b0, 1'b1, 3, 3'b001, 2'b10, 1'b1};
    tbl[10] = '{BEQ, 3'b000, 1'b0, 1'b0, 3, 3'b001, 2'b10, 1'b0};
    tbl[11] = '{JAL, 3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b11, 1'b1};
    tbl[12] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 2, 3'b000, 2'b00, 1'b0};

    // Reset held for two cycles
    reset = 1'b1; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset_hold%0d", i), act_s, reset_out(LW));
    end
    reset = 1'b0;
    run_instr(LW, 3'b000, 1'b0, 0, "lw_after_reset");

    foreach (tbl[i]) run_vec(tbl[i], i);

    run_instr(SW, 3'b010, 1'b0, 2, "sw");
    run_instr(BEQ, 3'b000, 1'b0, 1, "beq_taken");
    run_instr(BEQ, 3'b000, 1'b0, 0, "beq_not_taken");
    run_instr(7'b1111111, 3'b000, 1'b0, 2, "illegal");
    run_instr(JAL, 3'b000, 1'b0, 2, "jal");

    // Asynchronous reset between edges while in MEMWRITE
    op = SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    #1;
    check("memwrite_before_reset", act_s, model_out(SW, 3'b010, 1'b0, 1'b0, 4));
    #2 reset = 1'b1;
    #1;
    check("memwrite_async_abort", act_s, reset_out(SW));
    @(posedge clk); #1;
    check("reset_across_edge", act_s, reset_out(SW));
    reset = 1'b0;
    run_instr(SW, 3'b010, 1'b0, 2, "sw_after_abort");

    for (int n = 0; n < 80; n++) begin
      ro = ($urandom_range(0, 4) == 0) ? 7'($urandom) : legal[$urandom_range(0, 5)];
      run_instr(ro, 3'($urandom), 1'($urandom), 2, $sformatf("rand%0d_op%b", n, ro));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; state encoding, opcode and ALU-code constants come from the shared package.
REQ-002 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  instruction opcode, from IR[6:0].
REQ-005 funct3  input  3  from IR[14:12].
REQ-006 funct7b5  input  1  from IR[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 PCWrite  output  1  PC register enable.
REQ-009 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-010 MemWrite  output  1  data memory write enable.
REQ-011 IRWrite  output  1  instruction register enable.
REQ-012 ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-013 ALUSrcA  output  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-014 ALUSrcB  output  2  ALU operand B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-015 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 ImmSrc  output  2  immediate-extender format select: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-017 RegWrite  output  1  register-file write enable.

Function
REQ-018 The block SHALL be a Moore FSM with 11 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-019 Transitions: FETCH->DECODE, unconditionally.
REQ-020 Transitions from DECODE, by op:
- 0000011 (lw) or 0100011 (sw) -> MEMADR
- 0110011 (R-type) -> EXECUTER
- 0010011 (I-type ALU) -> EXECUTEI
- 1100011 (beq) -> BEQ
- 1101111 (jal) -> JAL
- any other op -> FETCH, with no register or memory write.
REQ-021 Transitions from MEMADR: -> MEMREAD for lw, -> MEMWRITE for sw.
REQ-022 Transitions: MEMREAD->MEMWB; EXECUTER->ALUWB; EXECUTEI->ALUWB; JAL->ALUWB.
REQ-023 Transitions: MEMWB, MEMWRITE, ALUWB and BEQ each -> FETCH.
REQ-024 FETCH outputs: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10, PCWrite=1.
REQ-025 DECODE outputs: ALUSrcA=01, ALUSrcB=01, ALUControl=add (branch-target precompute).
REQ-026 MEMADR outputs: ALUSrcA=10, ALUSrcB=01, ALUControl=add.
REQ-027 MEMREAD and MEMWRITE outputs: ResultSrc=00, AdrSrc=1; MEMWRITE additionally asserts MemWrite=1.
REQ-028 MEMWB outputs: ResultSrc=01, RegWrite=1.
REQ-029 EXECUTER outputs: ALUSrcA=10, ALUSrcB=00, ALUControl from the funct decode (REQ-034).
REQ-030 EXECUTEI outputs: ALUSrcA=10, ALUSrcB=01, ALUControl from the funct decode (REQ-034).
REQ-031 ALUWB outputs: ResultSrc=00, RegWrite=1.
REQ-032 BEQ outputs: ALUSrcA=10, ALUSrcB=00, ALUControl=sub, ResultSrc=00; PCWrite = zero (combinational, same cycle).
REQ-033 JAL outputs: ALUSrcA=01, ALUSrcB=10, ALUControl=add, ResultSrc=00, PCWrite=1.
REQ-034 Funct decode for R/I-type:
- funct3 000: sub only when op[5]=1 and funct7b5=1, otherwise add (addi never subtracts)
- funct3 010: slt
- funct3 110: or
- funct3 111: and
- any other funct3: add.
REQ-035 ImmSrc SHALL be a combinational function of op in every state: lw/I-type/default 00, sw 01, beq 10, jal 11.
REQ-036 In any state, any output not listed for that state SHALL be 0.
REQ-037 Each instruction's latency SHALL be exactly: lw 5 cycles, sw 4, R/I-type 4, jal 4, beq 3, illegal op 2.

Reset
REQ-038 Asserting reset SHALL force the state to FETCH immediately and asynchronously.
REQ-039 While reset is high, PCWrite, IRWrite, RegWrite and MemWrite SHALL be held 0; the select outputs take their FETCH values.
REQ-040 Reset asserted mid-instruction (e.g. in MEMWRITE) SHALL abort that instruction with no further write.
REQ-041 The first FETCH write enables SHALL occur on the first rising clk edge after reset deasserts.

Structure
REQ-042 The state enum, opcode constants and ALUControl/ImmSrc codes SHALL live in the shared package riscv_pkg.
REQ-043 Funct decoding SHALL be a sub-module, alu_decoder (inputs: aluop class, funct3, funct7b5, op5; output: ALUControl).
REQ-044 The FSM SHALL consist of a single state register plus combinational next-state and output logic.

Verification
REQ-045 Reset pulsed for 2 cycles, then op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in cycle 5.
REQ-046 op=0100011 -> MemWrite=1 exactly in cycle 4 with AdrSrc=1 and ImmSrc=01; back in FETCH at cycle 5.
REQ-047 op=1100011 with zero=1 -> PCWrite=1 in cycle 3; the same sequence with zero=0 -> PCWrite=0 in cycle 3; FETCH in cycle 4 in both cases.
REQ-048 op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; op=0010011, funct3=000, funct7b5=1 -> ALUControl=000 in EXECUTEI.
REQ-049 op=1111111 -> DECODE->FETCH with no RegWrite or MemWrite pulse; jal (op=1101111) -> ImmSrc=11, PCWrite=1 in the JAL state.
REQ-050 Reset asserted asynchronously between edges during MEMWRITE -> MemWrite drops to 0 the same cycle and the state reads FETCH.
